id_exe_hazard_reg: RTL and testbench

ID/EXE pipeline register with integrated hazard logic for the MIPS-like core. It captures decoded operands and control from the ID stage and presents them to the EXE stage. It also precomputes the 2-bit forwarding selects that drive the ALU port-A and port-B forwarding muxes (0 = register file/immediate, 1 = EXE_MEM forward, 2 = MEM_WB forward). It detects load-use hazards, stalls upstream and inserts bubbles, inserts bubbles on branch flush, and counts load-use stalls.

---
 rtl/id_exe_hazard_reg.sv | 158 +++++++++++++++
 tb/tb_id_exe_hazard_reg.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_exe_hazard_reg.sv
// id_exe_hazard_reg: ID/EXE pipeline register for the MIPS-like core.
// Captures decoded operands/control, precomputes the ALU forwarding selects,
// detects load-use hazards (stall + bubble), squashes on flush and counts
// load-use bubbles in a saturating counter.
module id_exe_hazard_reg #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5,
  parameter int CSIZE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [ASIZE-1:0] id_rs,
  input  logic [ASIZE-1:0] id_rt,
  input  logic             id_rt_used,
  input  logic             id_imm_sel,
  input  logic [DSIZE-1:0] id_rdata1,
  input  logic [DSIZE-1:0] id_rdata2_imm,
  input  logic [ASIZE-1:0] id_waddr,
  input  logic             id_wen,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic [3:0]       id_alu_op,
  input  logic [ASIZE-1:0] mem_waddr,
  input  logic             mem_wen,
  output logic             stall,
  output logic             ex_valid,
  output logic             ex_wen,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic [DSIZE-1:0] ex_rdata1,
  output logic [DSIZE-1:0] ex_rdata2_imm,
  output logic [ASIZE-1:0] ex_waddr,
  output logic [3:0]       ex_alu_op,
  output logic [1:0]       ex_fwdA_sel,
  output logic [1:0]       ex_fwdB_sel,
  output logic [CSIZE-1:0] stall_cnt
);

  localparam logic [ASIZE-1:0] REG_ZERO = {ASIZE{1'b0}};
  localparam logic [CSIZE-1:0] CNT_MAX  = {CSIZE{1'b1}};
  localparam logic [CSIZE-1:0] CNT_ONE  = {{(CSIZE-1){1'b0}}, 1'b1};

  logic             r_valid;
  logic             r_wen;
  logic             r_mem_read;
  logic             r_mem_write;
  logic [DSIZE-1:0] r_rdata1;
  logic [DSIZE-1:0] r_rdata2_imm;
  logic [ASIZE-1:0] r_waddr;
  logic [3:0]       r_alu_op;
  logic [1:0]       r_fwd_a;
  logic [1:0]       r_fwd_b;
  logic [CSIZE-1:0] r_stall_cnt;

  logic             w_use_a;
  logic             w_use_b;
  logic             w_use_b_alu;
  logic             w_stall;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  // Forward select for one operand: the instruction now in EXE (next in MEM)
  // beats the one now in MEM (next in WB); register 0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic             use_op,
    input logic [ASIZE-1:0] addr,
    input logic             exe_we,
    input logic [ASIZE-1:0] exe_wa,
    input logic             mem_we,
    input logic [ASIZE-1:0] mem_wa
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (use_op && exe_we && (exe_wa != REG_ZERO) && (exe_wa == addr)) begin
      sel = 2'd1;
    end else if (use_op && mem_we && (mem_wa != REG_ZERO) && (mem_wa == addr)) begin
      sel = 2'd2;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  // Operand-use qualifiers, load-use detection and forwarding selects for ID.
  always_comb begin
    w_use_a     = id_valid && (id_rs != REG_ZERO);
    w_use_b     = id_valid && id_rt_used && (id_rt != REG_ZERO);
    w_use_b_alu = w_use_b && !id_imm_sel;
    w_stall     = r_mem_read && r_wen && (r_waddr != REG_ZERO) &&
                  ((w_use_a && (r_waddr == id_rs)) || (w_use_b && (r_waddr == id_rt))) &&
                  !flush;
    w_fwd_a     = fwd_sel(w_use_a, id_rs, r_wen, r_waddr, mem_wen, mem_waddr);
    w_fwd_b     = fwd_sel(w_use_b_alu, id_rt, r_wen, r_waddr, mem_wen, mem_waddr);
  end

  // ID/EXE register: flush squashes, a load-use stall inserts a counted bubble,
  // otherwise the ID instruction and its selects advance into EXE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_wen        <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_rdata1     <= {DSIZE{1'b0}};
      r_rdata2_imm <= {DSIZE{1'b0}};
      r_waddr      <= REG_ZERO;
      r_alu_op     <= 4'd0;
      r_fwd_a      <= 2'd0;
      r_fwd_b      <= 2'd0;
      r_stall_cnt  <= {CSIZE{1'b0}};
    end else if (flush || w_stall) begin
      r_valid      <= 1'b0;
      r_wen        <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_rdata1     <= {DSIZE{1'b0}};
      r_rdata2_imm <= {DSIZE{1'b0}};
      r_waddr      <= REG_ZERO;
      r_alu_op     <= 4'd0;
      r_fwd_a      <= 2'd0;
      r_fwd_b      <= 2'd0;
      // w_stall is already masked by flush, so a flush never counts
      if (w_stall && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end else begin
      r_valid      <= id_valid;
      r_wen        <= id_wen;
      r_mem_read   <= id_mem_read;
      r_mem_write  <= id_mem_write;
      r_rdata1     <= id_rdata1;
      r_rdata2_imm <= id_rdata2_imm;
      r_waddr      <= id_waddr;
      r_alu_op     <= id_alu_op;
      r_fwd_a      <= w_fwd_a;
      r_fwd_b      <= w_fwd_b;
      r_stall_cnt  <= r_stall_cnt;
    end
  end

  assign stall         = w_stall;
  assign ex_valid      = r_valid;
  assign ex_wen        = r_wen;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_rdata1     = r_rdata1;
  assign ex_rdata2_imm = r_rdata2_imm;
  assign ex_waddr      = r_waddr;
  assign ex_alu_op     = r_alu_op;
  assign ex_fwdA_sel   = r_fwd_a;
  assign ex_fwdB_sel   = r_fwd_b;
  assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_id_exe_hazard_reg.sv
// Self-checking bench for id_exe_hazard_reg. Expected EXE-stage contents are
// queued when each ID instruction is driven and popped after the clock edge.
// The counter is built 2 bits wide so saturation is reachable quickly.
module tb_id_exe_hazard_reg;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 2;

  typedef struct packed {
    logic          flush;
    logic          valid;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          rt_used;
    logic          imm_sel;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [AW-1:0] waddr;
    logic          wen;
    logic          mr;
    logic          mw;
    logic [3:0]    alu;
    logic [AW-1:0] mwaddr;
    logic          mwen;
  } ins_t;

  typedef struct packed {
    logic          valid;
    logic          wen;
    logic          mr;
    logic          mw;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [AW-1:0] waddr;
    logic [3:0]    alu;
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush, id_valid, id_rt_used, id_imm_sel, id_wen, id_mem_read, id_mem_write, mem_wen;
  logic [AW-1:0] id_rs, id_rt, id_waddr, mem_waddr;
  logic [DW-1:0] id_rdata1, id_rdata2_imm;
  logic [3:0] id_alu_op;
  logic stall, ex_valid, ex_wen, ex_mem_read, ex_mem_write;
  logic [DW-1:0] ex_rdata1, ex_rdata2_imm;
  logic [AW-1:0] ex_waddr;
  logic [3:0] ex_alu_op;
  logic [1:0] ex_fwdA_sel, ex_fwdB_sel;
  logic [CW-1:0] stall_cnt;

  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;
  logic [CW-1:0] exp_cnt = 2'd0;

  id_exe_hazard_reg #(.DSIZE(DW), .ASIZE(AW), .CSIZE(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rt_used(id_rt_used), .id_imm_sel(id_imm_sel),
    .id_rdata1(id_rdata1), .id_rdata2_imm(id_rdata2_imm), .id_waddr(id_waddr),
    .id_wen(id_wen), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_alu_op(id_alu_op), .mem_waddr(mem_waddr), .mem_wen(mem_wen),
    .stall(stall), .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_rdata1(ex_rdata1), .ex_rdata2_imm(ex_rdata2_imm),
    .ex_waddr(ex_waddr), .ex_alu_op(ex_alu_op), .ex_fwdA_sel(ex_fwdA_sel),
    .ex_fwdB_sel(ex_fwdB_sel), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Builds an ID instruction; operand data encodes waddr and source regs.
  function automatic ins_t mk(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                              input logic ru, input logic imm, input logic [AW-1:0] wa,
                              input logic we, input logic mr, input logic mw, input logic [3:0] alu,
                              input logic [AW-1:0] mwa, input logic mwe, input logic fl);
    ins_t x;
    x.flush = fl; x.valid = v; x.rs = rs; x.rt = rt; x.rt_used = ru; x.imm_sel = imm;
    x.rd1 = {8'hA1, 11'd0, wa, 3'd0, rs};
    x.rd2 = {8'hB2, 11'd0, wa, 3'd0, rt};
    x.waddr = wa; x.wen = we; x.mr = mr; x.mw = mw; x.alu = alu;
    x.mwaddr = mwa; x.mwen = mwe;
    return x;
  endfunction

  // Expected EXE contents when instruction x is captured with the given selects.
  function automatic exp_t cap(input ins_t x, input logic [1:0] fa, input logic [1:0] fb,
                               input logic [CW-1:0] c);
    exp_t e;
    e.valid = x.valid; e.wen = x.wen; e.mr = x.mr; e.mw = x.mw;
    e.rd1 = x.rd1; e.rd2 = x.rd2; e.waddr = x.waddr; e.alu = x.alu;
    e.fa = fa; e.fb = fb; e.cnt = c;
    return e;
  endfunction

  // Expected EXE contents for a bubble.
  function automatic exp_t bub(input logic [CW-1:0] c);
    exp_t e;
    e = '0;
    e.cnt = c;
    return e;
  endfunction

  // Observed EXE contents.
  function automatic exp_t obs();
    exp_t o;
    o.valid = ex_valid; o.wen = ex_wen; o.mr = ex_mem_read; o.mw = ex_mem_write;
    o.rd1 = ex_rdata1; o.rd2 = ex_rdata2_imm; o.waddr = ex_waddr; o.alu = ex_alu_op;
    o.fa = ex_fwdA_sel; o.fb = ex_fwdB_sel; o.cnt = stall_cnt;
    return o;
  endfunction

  // Drives one ID-stage instruction at the falling edge and queues its expectation.
  task automatic step(input ins_t x, input exp_t e);
    @(negedge clk);
    flush = x.flush; id_valid = x.valid; id_rs = x.rs; id_rt = x.rt;
    id_rt_used = x.rt_used; id_imm_sel = x.imm_sel; id_rdata1 = x.rd1;
    id_rdata2_imm = x.rd2; id_waddr = x.waddr; id_wen = x.wen;
    id_mem_read = x.mr; id_mem_write = x.mw; id_alu_op = x.alu;
    mem_waddr = x.mwaddr; mem_wen = x.mwen;
    q.push_back(e);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_rt_used = 1'b0;
    id_imm_sel = 1'b0; id_rdata1 = 32'd0; id_rdata2_imm = 32'd0; id_waddr = 5'd0;
    id_wen = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0; id_alu_op = 4'd0;
    mem_waddr = 5'd0; mem_wen = 1'b0;
  endtask

  task automatic test_reset();
    ins_t x;
    exp_t got, want;
    idle_inputs();
    @(negedge clk);
    q.push_back(bub(2'd0));
    got = obs(); want = q.pop_front(); n_vec++;
    if (got !== want) begin $display("FAIL reset_init: got %h expected %h", got, want); n_err++; end
    @(negedge clk);
    rst_n = 1'b1;
    x = mk(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 4'h2, 5'd0, 1'b0, 1'b0);
    step(x, cap(x, 2'd0, 2'd0, 2'd0));
    @(posedge clk); #1;
    got = obs(); want = q.pop_front(); n_vec++;
    if (got !== want) begin $display("FAIL reset_cap: got %h expected %h", got, want); n_err++; end
    #2;
    rst_n = 1'b0;
    idle_inputs();
    q.push_back(bub(2'd0));
    #1;
    got = obs(); want = q.pop_front(); n_vec++;
    if (got !== want) begin $display("FAIL reset_async: got %h expected %h", got, want); n_err++; end
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 2'd0;
  endtask

  task automatic test_exe_fwd();
    ins_t xs[$]; exp_t es[$]; logic ss[$]; ins_t x; exp_t got, want;
    x = mk(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 4'h2, 5'd0, 1'b0, 1'b0);
    xs.push_back(x); ss.push_back(1'b0); es.push_back(cap(x, 2'd0, 2'd0, exp_cnt));
    x = mk(1'b1, 5'd3, 5'd4, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 4'h6, 5'd0, 1'b0, 1'b0);
    xs.push_back(x); ss.push_back(1'b0); es.push_back(cap(x, 2'd1, 2'd0, exp_cnt));
    for (int i = 0; i < xs.size(); i++) begin
      step(xs[i], es[i]);
      n_vec++;
      if (stall !== ss[i]) begin $display("FAIL exe_fwd_stall[%0d]: got %b expected %b", i, stall, ss[i]); n_err++; end
      @(posedge clk); #1;
      got = obs(); want = q.pop_front(); n_vec++;
      if (got !== want) begin $display("FAIL exe_fwd_ex[%0d]: got %h expected %h", i, got, want); n_err++; end
    end
  endtask

  task automatic test_mem_fwd();
    ins_t xs[$]; exp_t es[$]; logic ss[$]; ins_t x; exp_t got, want;
    x = mk(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 4'h2, 5'd3, 1'b1, 1'b0);
    xs.push_back(x); ss.push_back(1'b0); es.push_back(cap(x, 2'd0, 2'd0, exp_cnt));
    x = mk(1'b1, 5'd8, 5'd9, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 4'h5, 5'd6, 1'b1, 1'b0);
    xs.push_back(x); ss.push_back(1'b0); es.push_back(cap(x, 2'd0, 2'd0, exp_cnt));
    x = mk(1'b1, 5'd11, 5'd3, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 4'h7, 5'd3, 1'b1, 1'b0);
    xs.push_back(x); ss.push_back(1'b0); es.push_back(cap(x, 2'd0, 2'd2, exp_cnt));
    x = mk(1'b1, 5'd11, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 4'h2, 5'd3, 1'b1, 1'b0);
    xs.push_back(x); ss.push_back(1'b0); es.push_back(cap(x, 2'd0, 2'd0, exp_cnt));
    for (int i = 0; i < xs.size(); i++) begin
      step(xs[i], es[i]);
      n_vec++;
      if (stall !== ss[i]) begin $display("FAIL mem_fwd_stall[%0d]: got %b expected %b", i, stall, ss[i]); n_err++; end
      @(posedge clk); #1;
      got = obs(); want = q.pop_front(); n_vec++;
      if (got !== want) begin $display("FAIL mem_fwd_ex[%0d]: got %h expected %h", i, got, want); n_err++; end
    end
  endtask

  task automatic test_load_use();
    ins_t xs[$]; exp_t es[$]; logic ss[$]; ins_t x; exp_t got, want;
    x = mk(1'b1, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 4'h2, 5'd12, 1'b1, 1'b0);
    xs.push_back(x); ss.push_back(1'b0); es.push_back(cap(x, 2'd0, 2'd0, 2'd0));
    x = mk(1'b1, 5'd5, 5'd2, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 4'h2, 5'd0, 1'b0, 1'b0);
    xs.push_back(x); ss.push_back(1'b1); es.push_back(bub(2'd1));
    x = mk(1'b1, 5'd5, 5'd2, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 4'h2, 5'd5, 1'b1, 1'b0);
    xs.push_back(x); ss.push_back(1'b0); es.push_back(cap(x, 2'd2, 2'd0, 2'd1));
    for (int i = 0; i < xs.size(); i++) begin
      step(xs[i], es[i]);
      n_vec++;
      if (stall !== ss[i]) begin $display("FAIL load_use_stall[%0d]: got %b expected %b", i, stall, ss[i]); n_err++; end
      @(posedge clk); #1;
      got = obs(); want = q.pop_front(); n_vec++;
      if (got !== want) begin $display("FAIL load_use_ex[%0d]: got %h expected %h", i, got, want); n_err++; end
    end
    exp_cnt = 2'd1;
  endtask

  task automatic test_reg0_priority();
    ins_t xs[$]; exp_t es[$]; logic ss[$]; ins_t x; exp_t got, want;
    x = mk(1'b1, 5'd1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 4'h2, 5'd0, 1'b0, 1'b0);
    xs.push_back(x); ss.push_back(1'b0); es.push_back(cap(x, 2'd0, 2'd0, exp_cnt));
    x = mk(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd15, 1'b1, 1'b0, 1'b0, 4'h1, 5'd14, 1'b1, 1'b0);
    xs.push_back(x); ss.push_back(1'b0); es.push_back(cap(x, 2'd0, 2'd0, exp_cnt));
    x = mk(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 4'h2, 5'd0, 1'b1, 1'b0);
    xs.push_back(x); ss.push_back(1'b0); es.push_back(cap(x, 2'd0, 2'd0, exp_cnt));
    x = mk(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 4'h3, 5'd15, 1'b1, 1'b0);
    xs.push_back(x); ss.push_back(1'b0); es.push_back(cap(x, 2'd0, 2'd0, exp_cnt));
    x = mk(1'b1, 5'd7, 5'd7, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0, 4'h4, 5'd7, 1'b1, 1'b0);
    xs.push_back(x); ss.push_back(1'b0); es.push_back(cap(x, 2'd1, 2'd1, exp_cnt));
    for (int i = 0; i < xs.size(); i++) begin
      step(xs[i], es[i]);
      n_vec++;
      if (stall !== ss[i]) begin $display("FAIL reg0_prio_stall[%0d]: got %b expected %b", i, stall, ss[i]); n_err++; end
      @(posedge clk); #1;
      got = obs(); want = q.pop_front(); n_vec++;
      if (got !== want) begin $display("FAIL reg0_prio_ex[%0d]: got %h expected %h", i, got, want); n_err++; end
    end
  endtask

  task automatic test_flush();
    ins_t xs[$]; exp_t es[$]; logic ss[$]; ins_t x; exp_t got, want;
    x = mk(1'b1, 5'd2, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 4'h2, 5'd7, 1'b1, 1'b0);
    xs.push_back(x); ss.push_back(1'b0); es.push_back(cap(x, 2'd0, 2'd0, exp_cnt));
    x = mk(1'b1, 5'd9, 5'd3, 1'b1, 1'b0, 5'd17, 1'b1, 1'b0, 1'b0, 4'h2, 5'd16, 1'b1, 1'b1);
    xs.push_back(x); ss.push_back(1'b0); es.push_back(bub(exp_cnt));
    x = mk(1'b1, 5'd9, 5'd4, 1'b1, 1'b0, 5'd18, 1'b1, 1'b0, 1'b0, 4'h2, 5'd9, 1'b1, 1'b0);
    xs.push_back(x); ss.push_back(1'b0); es.push_back(cap(x, 2'd2, 2'd0, exp_cnt));
    for (int i = 0; i < xs.size(); i++) begin
      step(xs[i], es[i]);
      n_vec++;
      if (stall !== ss[i]) begin $display("FAIL flush_stall[%0d]: got %b expected %b", i, stall, ss[i]); n_err++; end
      @(posedge clk); #1;
      got = obs(); want = q.pop_front(); n_vec++;
      if (got !== want) begin $display("FAIL flush_ex[%0d]: got %h expected %h", i, got, want); n_err++; end
    end
  endtask

  task automatic test_saturate();
    ins_t xs[$]; exp_t es[$]; logic ss[$]; ins_t x; exp_t got, want;
    logic [AW-1:0] ra;
    for (int k = 0; k < 3; k++) begin
      ra = 5'd20 + 5'(k);
      x = mk(1'b1, 5'd1, ra, 1'b0, 1'b1, ra, 1'b1, 1'b1, 1'b0, 4'h2, 5'd0, 1'b0, 1'b0);
      xs.push_back(x); ss.push_back(1'b0); es.push_back(cap(x, 2'd0, 2'd0, exp_cnt));
      exp_cnt = (exp_cnt == 2'd3) ? 2'd3 : exp_cnt + 2'd1;
      x = mk(1'b1, 5'd3, ra, 1'b1, 1'b0, ra + 5'd5, 1'b1, 1'b0, 1'b0, 4'h2, 5'd0, 1'b0, 1'b0);
      xs.push_back(x); ss.push_back(1'b1); es.push_back(bub(exp_cnt));
      x = mk(1'b1, 5'd3, ra, 1'b1, 1'b0, ra + 5'd5, 1'b1, 1'b0, 1'b0, 4'h2, ra, 1'b1, 1'b0);
      xs.push_back(x); ss.push_back(1'b0); es.push_back(cap(x, 2'd0, 2'd2, exp_cnt));
    end
    for (int i = 0; i < xs.size(); i++) begin
      step(xs[i], es[i]);
      n_vec++;
      if (stall !== ss[i]) begin $display("FAIL saturate_stall[%0d]: got %b expected %b", i, stall, ss[i]); n_err++; end
      @(posedge clk); #1;
      got = obs(); want = q.pop_front(); n_vec++;
      if (got !== want) begin $display("FAIL saturate_ex[%0d]: got %h expected %h", i, got, want); n_err++; end
    end
  endtask

  initial begin
    test_reset();
    test_exe_fwd();
    test_mem_fwd();
    test_load_use();
    test_reg0_priority();
    test_flush();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
